comb_sweep_ctrl: RTL and testbench
==================================

COMB_SWEEP_CTRL -- requirements
Module: comb_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2: cycles vec is held stable before y_in is sampled, legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request one exhaustive sweep; accepted only in IDLE.
REQ-005 SHALL have port expect_tt, input, 16: expected truth table, bit i = expected Y for vec i; latched on start accept.
REQ-006 SHALL have port y_in, input, 1: output of the combinational block under control.
REQ-007 SHALL have port vec, output, 4: drives {A,B,C,D} of the block (A = MSB).
REQ-008 SHALL have port busy, output, 1: high from the cycle after start accept until FINISH.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at sweep end.
REQ-010 SHALL have port tt, output, 16: captured truth table, bit i = sampled y_in for vec i.
REQ-011 SHALL have port mismatch, output, 1: sticky; at least one sampled bit differed from expect_tt.
REQ-012 SHALL have port err_idx, output, 4: index of the first mismatching vector; valid when mismatch=1.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> SAMPLE -> (WAIT | FINISH) -> IDLE.
REQ-014 In IDLE, start=1 SHALL clear vec, tt, mismatch, err_idx and the settle counter, latch expect_tt, and enter WAIT.
REQ-015 WAIT SHALL last exactly SETTLE cycles, with vec constant, then enter SAMPLE.
REQ-016 SAMPLE SHALL write tt[vec] <= y_in; if y_in != latched expect_tt[vec] and mismatch=0, it SHALL set mismatch=1 and err_idx=vec.
REQ-017 From SAMPLE with vec != 15, SHALL increment vec, clear the counter, and enter WAIT; with vec = 15, SHALL enter FINISH, with no wrap past 15.
REQ-018 Each vector SHALL take SETTLE+1 cycles; done SHALL assert exactly 16*(SETTLE+1)+1 cycles after the start-accept edge.
REQ-019 FINISH SHALL assert done for one cycle with busy=0, then return to IDLE.
REQ-020 tt, mismatch and err_idx SHALL hold after FINISH until the next accepted start or reset.
REQ-021 start while busy, or in the FINISH cycle, SHALL be ignored; start on the first IDLE cycle after FINISH SHALL be accepted.
REQ-022 Changes on expect_tt after start accept SHALL have no effect on the current sweep.

Reset
REQ-023 rst=1 SHALL force IDLE, vec=0, busy=0, done=0, tt=0, mismatch=0, err_idx=0 and counter=0 at the next edge.
REQ-024 rst=1 SHALL take priority over start.
REQ-025 rst mid-sweep SHALL abandon the sweep and SHALL NOT produce a done pulse.

Configuration
REQ-026 Macro COMB_SWEEP_STOP_ON_ERR_EN defined: a SAMPLE that sets mismatch SHALL go directly to FINISH; tt bits above err_idx remain 0.
REQ-027 Macro COMB_SWEEP_STOP_ON_ERR_EN undefined: all 16 vectors SHALL always be swept regardless of mismatch.

Structure
REQ-028 Package comb_sweep_pkg SHALL hold the state enum type, N_VEC=16 and VEC_W=4.
REQ-029 The settle counter SHALL be a sub-module, sweep_settle_timer, with ports clk, rst, clear and expired.

Verification
(Y model for all cases: Y = A&B | C&D, giving truth table 0xF888; SETTLE=2.)
REQ-030 expect_tt=0xF888, start -> done at cycle 49 after accept; tt=0xF888, mismatch=0.
REQ-031 expect_tt=0xF88C, macro undefined -> done at cycle 49; mismatch=1, err_idx=2, tt=0xF888.
REQ-032 expect_tt=0xF88C, macro defined -> done at cycle 10; mismatch=1, err_idx=2, tt=0x0000.
REQ-033 start re-pulsed at cycle 10 of a sweep -> ignored; single done pulse at cycle 49; results as REQ-030.
REQ-034 rst at cycle 20 of a sweep -> next cycle busy=0, vec=0, tt=0, no done; a fresh start then completes per REQ-030.
REQ-035 start held high through FINISH -> new sweep accepted on the first IDLE cycle; second done pulse 49 cycles after that accept.

Source files
------------

// File: rtl/comb_sweep_pkg.sv
// Shared types and sizes for the exhaustive 4-input combinational sweep controller.
package comb_sweep_pkg;

  localparam int unsigned N_VEC = 16;
  localparam int unsigned VEC_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_FINISH
  } state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle counter: counts cycles since the last clear; expired flags the final settle cycle.
module sweep_settle_timer
  import comb_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Combinational so WAIT leaves on exactly the SETTLE-th cycle.
  assign expired = (cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Drives all 16 input vectors into a combinational block, captures its truth table and flags the first mismatch.
// Optional macro COMB_SWEEP_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expect_tt,
  input  logic        y_in,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        mismatch,
  output logic [3:0]  err_idx
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(N_VEC - 1);

  state_t            state;
  logic [N_VEC-1:0]  exp_q;
  logic              settle_clr_c;
  logic              expired;
  logic              hit_c;
  logic              stop_c;

  // Counter runs only while waiting; every other state holds it at zero.
  assign settle_clr_c = (state != S_WAIT);
  assign hit_c        = (y_in != exp_q[vec]);

`ifdef COMB_SWEEP_STOP_ON_ERR_EN
  assign stop_c = (vec == LAST_VEC) || (hit_c && !mismatch);
`else
  assign stop_c = (vec == LAST_VEC);
`endif

  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (settle_clr_c),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      vec      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= '0;
      mismatch <= 1'b0;
      err_idx  <= '0;
      exp_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec      <= '0;
            tt       <= '0;
            mismatch <= 1'b0;
            err_idx  <= '0;
            exp_q    <= expect_tt;
            busy     <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (expired) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          tt[vec] <= y_in;
          if (hit_c && !mismatch) begin
            mismatch <= 1'b1;
            err_idx  <= vec;
          end
          if (stop_c) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            vec   <= vec + VEC_W'(1);
            state <= S_WAIT;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Randomized self-checking bench for comb_sweep_ctrl against a truth-table level reference model.
module tb_comb_sweep_ctrl;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned CPV    = SETTLE + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] expect_tt;
  logic [15:0] blk_tt;
  logic        y_in;
  logic [3:0]  vec;
  logic [3:0]  vec_d;
  logic        busy;
  logic        done;
  logic [15:0] tt;
  logic        mismatch;
  logic [3:0]  err_idx;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  // Block under control: truth table lookup with one cycle of propagation delay.
  always @(posedge clk) vec_d <= vec;
  assign y_in = blk_tt[vec_d];

  comb_sweep_ctrl #(
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .expect_tt (expect_tt),
    .y_in      (y_in),
    .vec       (vec),
    .busy      (busy),
    .done      (done),
    .tt        (tt),
    .mismatch  (mismatch),
    .err_idx   (err_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: the sweep result follows directly from the block and expected tables.
  function automatic void model(input logic [15:0] blk, input logic [15:0] exp,
                                output int unsigned done_cyc, output logic [15:0] tt_e,
                                output logic mm, output logic [3:0] idx,
                                output int unsigned last);
    mm   = 1'b0;
    idx  = '0;
    last = 15;
    tt_e = blk;
    for (int i = 0; i < 16; i++) begin
      if (!mm && blk[i] != exp[i]) begin
        mm  = 1'b1;
        idx = 4'(i);
      end
    end
`ifdef COMB_SWEEP_STOP_ON_ERR_EN
    if (mm) begin
      last = 32'(idx);
      tt_e = blk & 16'((32'h1 << (32'(idx) + 1)) - 1);
    end
`endif
    // Cycle 1 is the cycle right after the accept edge.
    done_cyc = (last + 1) * CPV + 1;
  endfunction

  task automatic run_sweep(input string tag, input logic [15:0] blk, input logic [15:0] exp,
                           input int unsigned repulse_at, input int unsigned rst_at,
                           input bit hold_start);
    int unsigned done_cyc, last, exp_vec;
    logic [15:0] tt_e;
    logic        mm;
    logic [3:0]  idx;
    model(blk, exp, done_cyc, tt_e, mm, idx, last);
    blk_tt    = blk;
    expect_tt = exp;
    start     = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    expect_tt = ~exp;
    for (int unsigned c = 1; c <= done_cyc; c++) begin
      exp_vec = ((c - 1) / CPV > last) ? last : (c - 1) / CPV;
      check($sformatf("%s vec c%0d", tag, c), 32'(vec), exp_vec);
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c < done_cyc));
      check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == done_cyc));
      if (c == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check({tag, " rst busy"}, 32'(busy), 32'd0);
        check({tag, " rst vec"}, 32'(vec), 32'd0);
        check({tag, " rst tt"}, 32'(tt), 32'd0);
        check({tag, " rst mismatch"}, 32'(mismatch), 32'd0);
        for (int k = 0; k < 60; k++) begin
          check({tag, " no done after rst"}, 32'(done), 32'd0);
          @(posedge clk); #1;
        end
        return;
      end
      start = hold_start || (c == repulse_at);
      if (c < done_cyc) begin
        @(posedge clk); #1;
      end
    end
    check({tag, " tt"}, 32'(tt), 32'(tt_e));
    check({tag, " mismatch"}, 32'(mismatch), 32'(mm));
    check({tag, " err_idx"}, 32'(err_idx), 32'(idx));
    @(posedge clk); #1;
    check({tag, " idle done"}, 32'(done), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " hold tt"}, 32'(tt), 32'(tt_e));
    check({tag, " hold mismatch"}, 32'(mismatch), 32'(mm));
    check({tag, " hold err_idx"}, 32'(err_idx), 32'(idx));
  endtask

  initial begin
    logic [15:0] r_blk, r_exp;
    rst       = 1'b1;
    start     = 1'b1;
    expect_tt = 16'h0;
    blk_tt    = 16'hF888;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset vec", 32'(vec), 32'd0);
    check("reset tt", 32'(tt), 32'd0);
    check("reset mismatch", 32'(mismatch), 32'd0);
    check("reset err_idx", 32'(err_idx), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;

    run_sweep("match", 16'hF888, 16'hF888, 0, 0, 1'b0);
    run_sweep("mismatch", 16'hF888, 16'hF88C, 0, 0, 1'b0);
    run_sweep("repulse", 16'hF888, 16'hF888, 10, 0, 1'b0);
    run_sweep("mid_rst", 16'hF888, 16'hF888, 0, 20, 1'b0);
    run_sweep("after_rst", 16'hF888, 16'hF888, 0, 0, 1'b0);
    run_sweep("held1", 16'hF888, 16'h0F0F, 0, 0, 1'b1);
    run_sweep("held2", 16'hF888, 16'hF888, 0, 0, 1'b0);
    run_sweep("last_vec", 16'hF888, 16'h7888, 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      r_blk = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       r_exp = r_blk;
        1:       r_exp = r_blk ^ 16'(32'h1 << $urandom_range(0, 15));
        default: r_exp = 16'($urandom);
      endcase
      run_sweep($sformatf("rand%0d", i), r_blk, r_exp, $urandom_range(0, 40), 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
